// File: rtl/accum_ctrl_pkg.sv
// accum_ctrl_pkg
// Shared types and widths for the accumulator sequencer.
//   ctrl_state_t  : sequencer state encoding
//   ACC_W/CNT_W/SW_W : datapath widths
//   sum_overflows : true when sw + acc does not fit in ACC_W bits
package accum_ctrl_pkg;

  localparam int ACC_W = 16;
  localparam int CNT_W = 8;
  localparam int SW_W  = 8;

  typedef enum logic [2:0] {
    IDLE,
    COMMIT,
    WAIT_REL,
    CLEAR,
    CLR_REL
  } ctrl_state_t;

  // One extra bit of headroom so the carry out of the add is the overflow flag.
  function automatic logic sum_overflows(input logic [SW_W-1:0]  sw,
                                         input logic [ACC_W-1:0] acc);
    logic [ACC_W:0] sum;
    sum = {{(ACC_W - SW_W + 1){1'b0}}, sw} + {1'b0, acc};
    return sum[ACC_W];
  endfunction

endpackage

// File: rtl/accum_ctrl_debounce_sync.sv
// debounce_sync
// Two-flop synchronizer followed by a level debouncer for one active-low
// button. The debounced level follows the synchronized input only after it
// has disagreed with the current level on DB_CYCLES+1 consecutive samples.
//   clk, rst_n : clock, synchronous active-low reset
//   btn_n      : raw button, asynchronous to clk
//   level      : debounced button level (1 = released)
module debounce_sync #(
  parameter int DB_CYCLES = 50000
) (
  input  logic clk,
  input  logic rst_n,
  input  logic btn_n,
  output logic level
);

  localparam int CW = $clog2(DB_CYCLES + 1);
  localparam logic [CW-1:0] CNT_TC = CW'(DB_CYCLES);

  logic          sync_1;
  logic          sync_2;
  logic [CW-1:0] cnt;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      sync_1 <= 1'b1;
      sync_2 <= 1'b1;
      level  <= 1'b1;
      cnt    <= '0;
    end else begin
      sync_1 <= btn_n;
      sync_2 <= sync_1;
      // Any sample that agrees with the current level restarts the run.
      if (sync_2 == level) begin
        cnt <= '0;
      end else if (cnt == CNT_TC) begin
        level <= sync_2;
        cnt   <= '0;
      end else begin
        cnt <= cnt + CW'(1);
      end
    end
  end

endmodule

// File: rtl/accum_ctrl.sv
// accum_ctrl
// Turns the add/clear push buttons into single-cycle strobes for the
// accumulator and entry counter, rejecting adds that would overflow the sum
// or wrap the count.
//   clk, rst_n       : clock, synchronous active-low reset
//   add_n, clr_n     : raw active-low buttons
//   sw_in            : operand to add
//   acc_in, cnt_in   : current accumulator value and entry count
//   acc_en, cnt_en   : load / increment strobes (one cycle)
//   acc_clr          : clear strobe for accumulator and counter (one cycle)
//   ovf, full        : sticky rejection flags, cleared by CLEAR
//   busy             : sequencer not in IDLE
//
// state    | meaning
// IDLE     | waiting for a button press
// COMMIT   | one cycle: strobe the add or record why it was rejected
// WAIT_REL | add done, waiting for add release (clear still honoured)
// CLEAR    | one cycle: strobe the clear, drop sticky flags
// CLR_REL  | waiting for both buttons released
module accum_ctrl
  import accum_ctrl_pkg::*;
#(
  parameter int DB_CYCLES = 50000
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             add_n,
  input  logic             clr_n,
  input  logic [SW_W-1:0]  sw_in,
  input  logic [ACC_W-1:0] acc_in,
  input  logic [CNT_W-1:0] cnt_in,
  output logic             acc_en,
  output logic             cnt_en,
  output logic             acc_clr,
  output logic             ovf,
  output logic             full,
  output logic             busy
);

  ctrl_state_t state, state_nxt;
  logic        add_lvl, clr_lvl;
  logic        blk_ovf, blk_full, blocked;

  debounce_sync #(.DB_CYCLES(DB_CYCLES)) u_db_add (
    .clk   (clk),
    .rst_n (rst_n),
    .btn_n (add_n),
    .level (add_lvl)
  );

  debounce_sync #(.DB_CYCLES(DB_CYCLES)) u_db_clr (
    .clk   (clk),
    .rst_n (rst_n),
    .btn_n (clr_n),
    .level (clr_lvl)
  );

  assign blk_ovf  = sum_overflows(sw_in, acc_in);
  assign blk_full = (cnt_in == {CNT_W{1'b1}});
  assign blocked  = blk_ovf | blk_full;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    acc_en    = 1'b0;
    cnt_en    = 1'b0;
    acc_clr   = 1'b0;
    busy      = (state != IDLE);
    case (state)
      IDLE: begin
        if (!clr_lvl)      state_nxt = CLEAR;
        else if (!add_lvl) state_nxt = COMMIT;
      end
      COMMIT: begin
        acc_en    = !blocked;
        cnt_en    = !blocked;
        state_nxt = WAIT_REL;
      end
      WAIT_REL: begin
        if (!clr_lvl)     state_nxt = CLEAR;
        else if (add_lvl) state_nxt = IDLE;
      end
      CLEAR: begin
        acc_clr   = 1'b1;
        state_nxt = CLR_REL;
      end
      CLR_REL: begin
        if (clr_lvl && add_lvl) state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  // Flags latch the rejection reason at the end of COMMIT; a reset taken on
  // that same edge wins so nothing is recorded for an aborted commit.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      ovf  <= 1'b0;
      full <= 1'b0;
    end else if (state == CLEAR) begin
      ovf  <= 1'b0;
      full <= 1'b0;
    end else if (state == COMMIT) begin
      if (blk_ovf)  ovf  <= 1'b1;
      if (blk_full) full <= 1'b1;
    end
  end

endmodule

// File: tb/tb_accum_ctrl.sv
module tb_accum_ctrl;

  localparam int DB = 4;

  logic        clk = 1'b0;
  logic        rst_n, add_n, clr_n;
  logic [7:0]  sw_in, cnt_in;
  logic [15:0] acc_in;
  logic        acc_en, cnt_en, acc_clr, ovf, full, busy;

  always #5 clk = ~clk;

  accum_ctrl #(.DB_CYCLES(DB)) dut (
    .clk     (clk),
    .rst_n   (rst_n),
    .add_n   (add_n),
    .clr_n   (clr_n),
    .sw_in   (sw_in),
    .acc_in  (acc_in),
    .cnt_in  (cnt_in),
    .acc_en  (acc_en),
    .cnt_en  (cnt_en),
    .acc_clr (acc_clr),
    .ovf     (ovf),
    .full    (full),
    .busy    (busy)
  );

  int total = 0;
  int bad   = 0;
  int cyc   = 0;
  bit chk_on = 0;

  // Behavioural model: button delay line, "last DB+1 samples disagree"
  // debounce rule, and a press-handling phase.
  localparam int PH_IDLE = 0, PH_ADD = 1, PH_HOLD = 2, PH_CLR = 3, PH_CLR_HOLD = 4;
  int m_ph;
  bit m_ovf, m_full;
  bit m_add_d1, m_add_d2, m_clr_d1, m_clr_d2;
  bit m_add_lvl, m_clr_lvl;
  bit hist_add[$];
  bit hist_clr[$];

  int n_acc = 0, n_cnt = 0, n_clr = 0, n_busy = 0;
  int first_acc = -1;

  function automatic bit sum_too_big();
    return (int'(acc_in) + int'(sw_in)) > 65535;
  endfunction

  function automatic bit add_ok();
    return !sum_too_big() && (cnt_in != 8'd255);
  endfunction

  task automatic cmp(input string name, input logic act, input logic exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s at cycle %0d: got %b want %b", name, cyc, act, exp);
    end
  endtask

  task automatic check_int(input string name, input int act, input int exp);
    total++;
    if (act != exp) begin
      bad++;
      $display("FAIL %s at cycle %0d: got %0d want %0d", name, cyc, act, exp);
    end
  endtask

  always @(posedge clk) begin
    bit diff;
    cyc++;
    if (!rst_n) begin
      m_ph = PH_IDLE;
      m_ovf = 0;
      m_full = 0;
      m_add_d1 = 1; m_add_d2 = 1; m_clr_d1 = 1; m_clr_d2 = 1;
      m_add_lvl = 1; m_clr_lvl = 1;
      hist_add.delete();
      hist_clr.delete();
    end else begin
      case (m_ph)
        PH_IDLE:     if (!m_clr_lvl) m_ph = PH_CLR; else if (!m_add_lvl) m_ph = PH_ADD;
        PH_ADD: begin
          if (sum_too_big()) m_ovf = 1;
          if (cnt_in == 8'd255) m_full = 1;
          m_ph = PH_HOLD;
        end
        PH_HOLD:     if (!m_clr_lvl) m_ph = PH_CLR; else if (m_add_lvl) m_ph = PH_IDLE;
        PH_CLR: begin
          m_ovf = 0;
          m_full = 0;
          m_ph = PH_CLR_HOLD;
        end
        default:     if (m_clr_lvl && m_add_lvl) m_ph = PH_IDLE;
      endcase
      hist_add.push_back(m_add_d2);
      if (hist_add.size() > DB + 1) void'(hist_add.pop_front());
      if (hist_add.size() == DB + 1) begin
        diff = 1;
        foreach (hist_add[i]) if (hist_add[i] == m_add_lvl) diff = 0;
        if (diff) m_add_lvl = m_add_d2;
      end
      hist_clr.push_back(m_clr_d2);
      if (hist_clr.size() > DB + 1) void'(hist_clr.pop_front());
      if (hist_clr.size() == DB + 1) begin
        diff = 1;
        foreach (hist_clr[i]) if (hist_clr[i] == m_clr_lvl) diff = 0;
        if (diff) m_clr_lvl = m_clr_d2;
      end
      m_add_d2 = m_add_d1; m_add_d1 = add_n;
      m_clr_d2 = m_clr_d1; m_clr_d1 = clr_n;
    end
  end

  always @(negedge clk) begin
    if (chk_on) begin
      cmp("acc_en",  acc_en,  (m_ph == PH_ADD) && add_ok());
      cmp("cnt_en",  cnt_en,  (m_ph == PH_ADD) && add_ok());
      cmp("acc_clr", acc_clr, m_ph == PH_CLR);
      cmp("ovf",     ovf,     m_ovf);
      cmp("full",    full,    m_full);
      cmp("busy",    busy,    m_ph != PH_IDLE);
      if (acc_en === 1'b1) begin
        n_acc++;
        if (first_acc < 0) first_acc = cyc;
      end
      if (cnt_en === 1'b1)  n_cnt++;
      if (acc_clr === 1'b1) n_clr++;
      if (busy === 1'b1)    n_busy++;
    end
  end

  task automatic tick(input int n);
    repeat (n) begin
      @(posedge clk);
      #2;
    end
  endtask

  task automatic press_add(input int hold, input int rel);
    add_n = 0;
    tick(hold);
    add_n = 1;
    tick(rel);
  endtask

  initial begin
    int a0, c0, l0, b0, press_edge, r;
    rst_n = 0; add_n = 1; clr_n = 1;
    sw_in = 0; acc_in = 0; cnt_in = 0;
    @(posedge clk); #2;
    chk_on = 1;
    @(negedge clk);
    check_int("reset_busy", int'(busy), 0);
    check_int("reset_strobes", int'(acc_en) + int'(cnt_en) + int'(acc_clr), 0);
    check_int("reset_flags", int'(ovf) + int'(full), 0);
    #2;
    tick(2);
    rst_n = 1;
    tick(3);

    // single add with latency check
    sw_in = 8'h2A; acc_in = 16'h0010; cnt_in = 8'h03;
    a0 = n_acc; c0 = n_cnt; first_acc = -1;
    press_edge = cyc + 1;
    press_add(20, 12);
    check_int("single_add_acc_pulses", n_acc - a0, 1);
    check_int("single_add_cnt_pulses", n_cnt - c0, 1);
    check_int("single_add_latency", first_acc - press_edge, 7);

    // glitch shorter than DB
    a0 = n_acc; b0 = n_busy;
    press_add(3, 12);
    check_int("glitch_no_strobe", n_acc - a0, 0);
    check_int("glitch_no_busy", n_busy - b0, 0);

    // overflow, then exact FFFF boundary
    acc_in = 16'hFFF0; sw_in = 8'h10; cnt_in = 8'h05;
    a0 = n_acc;
    press_add(10, 12);
    check_int("ovf_rejected", n_acc - a0, 0);
    check_int("ovf_set", int'(ovf), 1);
    sw_in = 8'h0F;
    a0 = n_acc;
    press_add(10, 12);
    check_int("ffff_accepted", n_acc - a0, 1);
    check_int("ovf_sticky", int'(ovf), 1);

    // count boundary FE accepted, FF rejected
    acc_in = 16'h0000; sw_in = 8'h01; cnt_in = 8'hFE;
    a0 = n_acc;
    press_add(10, 12);
    check_int("cnt_fe_accepted", n_acc - a0, 1);
    check_int("cnt_fe_not_full", int'(full), 0);
    cnt_in = 8'hFF;
    a0 = n_acc;
    press_add(10, 12);
    check_int("full_rejected", n_acc - a0, 0);
    check_int("full_set", int'(full), 1);

    // clear while add held in WAIT_REL
    cnt_in = 8'h03;
    add_n = 0;
    tick(10);
    a0 = n_acc; l0 = n_clr;
    clr_n = 0;
    tick(15);
    check_int("clear_pulses", n_clr - l0, 1);
    check_int("clear_ovf", int'(ovf), 0);
    check_int("clear_full", int'(full), 0);
    clr_n = 1;
    tick(15);
    check_int("clr_rel_no_add", n_acc - a0, 0);
    check_int("clr_rel_busy", int'(busy), 1);
    add_n = 1;
    tick(12);
    check_int("clr_rel_idle", int'(busy), 0);
    a0 = n_acc;
    press_add(10, 12);
    check_int("add_after_clear", n_acc - a0, 1);

    // simultaneous press: clear wins
    a0 = n_acc; l0 = n_clr;
    add_n = 0; clr_n = 0;
    tick(12);
    add_n = 1; clr_n = 1;
    tick(12);
    check_int("both_clear_wins", n_clr - l0, 1);
    check_int("both_no_add", n_acc - a0, 0);

    // randomized traffic, including resets mid-operation
    for (int it = 0; it < 300; it++) begin
      r = $urandom_range(0, 99);
      case ($urandom_range(0, 2))
        0: acc_in = 16'($urandom);
        1: acc_in = 16'hFF00 + 16'($urandom_range(0, 255));
        default: acc_in = 16'hFFFF;
      endcase
      case ($urandom_range(0, 2))
        0: cnt_in = 8'($urandom);
        1: cnt_in = 8'hFE;
        default: cnt_in = 8'hFF;
      endcase
      sw_in = 8'($urandom);
      if (r < 5) begin
        rst_n = 0;
        tick($urandom_range(1, 2));
        rst_n = 1;
      end else begin
        add_n = (r < 60) ? 1'b0 : 1'b1;
        clr_n = (r > 85) ? 1'b0 : 1'b1;
        tick($urandom_range(1, 12));
      end
    end
    add_n = 1; clr_n = 1;
    tick(20);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
